// File: rtl/uart_tx_if.sv
// Byte-producer side of the UART transmitter: write strobe and data in, line and status out.
interface uart_tx_if;
    logic [7:0] pi_data;
    logic       pi_flag;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic       overrun;

    modport master (
        output pi_data, pi_flag,
        input  tx_ready, tx, tx_busy, tx_done, overrun
    );

    modport slave (
        input  pi_data, pi_flag,
        output tx_ready, tx, tx_busy, tx_done, overrun
    );
endinterface

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// A one-byte holding register in front of the shift register lets frames run back to back.
module uart_tx #(
    parameter int UART_BPS  = 9600,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic     sys_clk,
    input  logic     sys_rst,
    uart_tx_if.slave bus
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int CNT_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             tx_done_q, tx_done_d;
    logic             overrun_q, overrun_d;
    logic             bit_end;
    logic             load;

    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        tx_d         = tx_q;
        tx_done_d    = 1'b0;
        overrun_d    = 1'b0;
        load         = 1'b0;
        bit_end      = (baud_cnt_q == BAUD_LAST);

        // Acceptance looks only at the registered hold-valid bit, so a drain and a write never pair up.
        if (bus.pi_flag) begin
            if (hold_valid_q) begin
                overrun_d = 1'b1;
            end else begin
                hold_d       = bus.pi_data;
                hold_valid_d = 1'b1;
            end
        end

        if (state_q != S_IDLE) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (hold_valid_q) load = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = (PARITY == 1) ? ~par_q : par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        tx_done_d = 1'b1;
                        bit_cnt_d = 3'd0;
                        if (hold_valid_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Moving hold into the shifter also drives the start bit on the same edge.
        if (load) begin
            state_d      = S_START;
            shift_d      = hold_q;
            par_d        = ^hold_q;
            hold_valid_d = 1'b0;
            tx_d         = 1'b0;
            baud_cnt_d   = '0;
            bit_cnt_d    = 3'd0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            tx_done_q    <= tx_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = ~hold_valid_q;
    assign bus.tx_busy  = busy_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (no parity, even, odd, two stop bits) at 10 clocks per bit,
// with a per-instance serial decoder checking frames against queued hand-computed expectations.
module tb_uart_tx;
    typedef struct packed {
        logic [7:0]  data;
        logic        par;
        logic        trunc;
        logic [15:0] len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] flag_a = 4'h0;
    logic [7:0] data_a [4];
    logic [3:0] tx_a, ready_a, busy_a, done_a, ovr_a;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt [4] = '{0, 0, 0, 0};
    int done_gap [4] = '{0, 0, 0, 0};
    int last_done [4] = '{0, 0, 0, 0};
    int ovr_cnt [4] = '{0, 0, 0, 0};
    int busy_run [4] = '{0, 0, 0, 0};
    int last_busy [4] = '{0, 0, 0, 0};

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_cfg
        uart_tx_if bus ();
        assign bus.pi_flag = flag_a[i];
        assign bus.pi_data = data_a[i];
        assign tx_a[i]     = bus.tx;
        assign ready_a[i]  = bus.tx_ready;
        assign busy_a[i]   = bus.tx_busy;
        assign done_a[i]   = bus.tx_done;
        assign ovr_a[i]    = bus.overrun;

        uart_tx #(
            .UART_BPS (100),
            .CLK_FREQ (1000),
            .PARITY   ((i == 1) ? 2 : (i == 2) ? 1 : 0),
            .STOP_BITS((i == 3) ? 2 : 1)
        ) dut (
            .sys_clk(clk),
            .sys_rst(rst),
            .bus    (bus.slave)
        );
    end

    function automatic int cfg_par(input int k);
        return (k == 1) ? 2 : (k == 2) ? 1 : 0;
    endfunction

    function automatic void q_push(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endfunction

    function automatic bit q_pop(input int k, output exp_t e);
        e = '0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); return 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    function automatic int q_size(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, act, want, cyc);
        end
    endtask

    // Drives one write strobe; only bytes the bench expects to be accepted and sent are queued.
    task automatic applyStimulus(input int k, input logic [7:0] d, input bit push,
                                 input logic par, input int len, input bit trunc);
        exp_t e;
        e.data  = d;
        e.par   = par;
        e.trunc = trunc;
        e.len   = 16'(len);
        if (push) q_push(k, e);
        @(negedge clk);
        data_a[k] = d;
        flag_a[k] = 1'b1;
        @(negedge clk);
        flag_a[k] = 1'b0;
        data_a[k] = 8'hxx;
    endtask

    task automatic run_frame(input int k, output bit aborted);
        exp_t        e;
        logic [11:0] bits;
        int          first_stop;
        int          nbits;
        aborted = 1'b0;
        bits    = '1;
        if (!q_pop(k, e)) begin
            checkOutput("unexpected_frame", 32'd1, 32'd0);
            e.data  = 8'h00;
            e.par   = 1'b0;
            e.trunc = 1'b0;
            e.len   = 16'd100;
        end
        for (int off = 0; off <= int'(e.len); off++) begin
            if (off > 0) @(negedge clk);
            if (rst) begin
                aborted = 1'b1;
                break;
            end
            if ((off % 10) == 5 && (off / 10) < 12) bits[off / 10] = tx_a[k];
            if (off == int'(e.len) - 1) checkOutput("done_before_end", 32'(done_a[k]), 32'd0);
            if (off == int'(e.len)) checkOutput("done_at_end", 32'(done_a[k]), 32'd1);
        end
        checkOutput("frame_truncated", 32'(aborted), 32'(e.trunc));
        if (aborted) return;
        nbits      = int'(e.len) / 10;
        first_stop = (cfg_par(k) != 0) ? 10 : 9;
        checkOutput("start_bit", 32'(bits[0]), 32'd0);
        checkOutput("data_byte", 32'(bits[8:1]), 32'(e.data));
        if (cfg_par(k) != 0) checkOutput("parity_bit", 32'(bits[9]), 32'(e.par));
        for (int b = first_stop; b < nbits; b++) checkOutput("stop_bit", 32'(bits[b]), 32'd1);
    endtask

    task automatic monitor(input int k);
        logic prev;
        bit   aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            while (!rst && prev && tx_a[k] == 1'b0) begin
                run_frame(k, aborted);
                prev = 1'b1;
                if (aborted) break;
            end
            prev = rst ? 1'b1 : tx_a[k];
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 4; k++) begin
                if (done_a[k] === 1'b1) begin
                    done_cnt[k]++;
                    done_gap[k]  = cyc - last_done[k];
                    last_done[k] = cyc;
                end
                if (ovr_a[k] === 1'b1) ovr_cnt[k]++;
                if (busy_a[k] === 1'b1) begin
                    busy_run[k]++;
                end else begin
                    if (busy_run[k] != 0) last_busy[k] = busy_run[k];
                    busy_run[k] = 0;
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) data_a[k] = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checkOutput("reset_tx", 32'(tx_a[k]), 32'd1);
            checkOutput("reset_ready", 32'(ready_a[k]), 32'd1);
            checkOutput("reset_busy", 32'(busy_a[k]), 32'd0);
            checkOutput("reset_done", 32'(done_a[k]), 32'd0);
            checkOutput("reset_overrun", 32'(ovr_a[k]), 32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame, then ready/tx timing right after accept.
        applyStimulus(0, 8'h55, 1'b1, 1'b0, 100, 1'b0);
        checkOutput("ready_after_accept", 32'(ready_a[0]), 32'd0);
        @(negedge clk);
        checkOutput("ready_restored", 32'(ready_a[0]), 32'd1);
        checkOutput("tx_fall", 32'(tx_a[0]), 32'd0);
        checkOutput("busy_set", 32'(busy_a[0]), 32'd1);
        repeat (110) @(negedge clk);
        checkOutput("done_count_single", 32'(done_cnt[0]), 32'd1);
        checkOutput("busy_len_single", 32'(last_busy[0]), 32'd100);

        // Back to back with an overrun on the third byte.
        applyStimulus(0, 8'hA5, 1'b1, 1'b0, 100, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(0, 8'h3C, 1'b1, 1'b0, 100, 1'b0);
        repeat (10) @(negedge clk);
        applyStimulus(0, 8'h99, 1'b0, 1'b0, 100, 1'b0);
        checkOutput("overrun_pulse", 32'(ovr_a[0]), 32'd1);
        checkOutput("ready_while_full", 32'(ready_a[0]), 32'd0);
        @(negedge clk);
        checkOutput("overrun_one_cycle", 32'(ovr_a[0]), 32'd0);
        repeat (230) @(negedge clk);
        checkOutput("done_count_b2b", 32'(done_cnt[0]), 32'd3);
        checkOutput("done_gap_b2b", 32'(done_gap[0]), 32'd100);
        checkOutput("busy_len_b2b", 32'(last_busy[0]), 32'd200);
        checkOutput("overrun_count", 32'(ovr_cnt[0]), 32'd1);

        // Even parity (cfg 1), odd parity (cfg 2), two stop bits (cfg 3).
        applyStimulus(1, 8'h07, 1'b1, 1'b1, 110, 1'b0);
        applyStimulus(2, 8'h07, 1'b1, 1'b0, 110, 1'b0);
        applyStimulus(3, 8'hFF, 1'b1, 1'b0, 110, 1'b0);
        applyStimulus(1, 8'h03, 1'b1, 1'b0, 110, 1'b0);
        applyStimulus(2, 8'h03, 1'b1, 1'b1, 110, 1'b0);
        applyStimulus(3, 8'h80, 1'b1, 1'b0, 110, 1'b0);
        repeat (250) @(negedge clk);
        for (int k = 1; k < 4; k++) begin
            checkOutput("done_count_cfg", 32'(done_cnt[k]), 32'd2);
            checkOutput("done_gap_cfg", 32'(done_gap[k]), 32'd110);
        end

        // Reset during data bit 3 with a second byte waiting in hold.
        applyStimulus(0, 8'hC3, 1'b1, 1'b0, 100, 1'b1);
        repeat (5) @(negedge clk);
        applyStimulus(0, 8'h11, 1'b0, 1'b0, 100, 1'b0);
        repeat (37) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_tx", 32'(tx_a[0]), 32'd1);
        checkOutput("rst_mid_ready", 32'(ready_a[0]), 32'd1);
        checkOutput("rst_mid_busy", 32'(busy_a[0]), 32'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("post_rst_tx_idle", 32'(tx_a[0]), 32'd1);
        checkOutput("post_rst_busy", 32'(busy_a[0]), 32'd0);
        applyStimulus(0, 8'h5A, 1'b1, 1'b0, 100, 1'b0);
        repeat (110) @(negedge clk);
        checkOutput("done_count_final", 32'(done_cnt[0]), 32'd4);
        checkOutput("overrun_count_final", 32'(ovr_cnt[0]), 32'd1);
        for (int k = 0; k < 4; k++) checkOutput("queue_drained", 32'(q_size(k)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
